load_store_unit: RTL and testbench

Memory-stage load/store unit for the 64-bit RV64I pipeline. It accepts one access per instruction from the EX/MEM stage and drives a request/ready data-memory port. For stores it builds doubleword-aligned strobes and write data; for loads it extracts the addressed byte lane and sign- or zero-extends it. Its registered `mem_data` output feeds the write-back stage's memory-data input, and it stalls the pipeline while an access is outstanding.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/load_store_unit_if.sv | 37 +++
 rtl/load_align.sv | 32 +++
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV64I memory-stage load/store unit.
// funct3 size/sign encodings and the access FSM state type.
package lsu_pkg;

    localparam int LSU_XLEN = 64;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/ready port between the load/store unit and memory.
// master = unit side, slave = memory side.
interface load_store_unit_if
    import lsu_pkg::*;
#(
    parameter int XLEN = LSU_XLEN
) ();

    logic              dmem_req;
    logic              dmem_we;
    logic [XLEN-1:0]   dmem_addr;
    logic [XLEN-1:0]   dmem_wdata;
    logic [XLEN/8-1:0] dmem_wstrb;
    logic              dmem_ready;
    logic [XLEN-1:0]   dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_wstrb,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_wstrb,
        output dmem_ready,
        output dmem_rdata
    );

endinterface

// File: rtl/load_align.sv
// Load formatter: selects the addressed lane of a read doubleword
// and sign- or zero-extends it according to funct3.
module load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = LSU_XLEN
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      addr,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] s;

    assign s = rdata >> {addr, 3'b000};

    always_comb begin
        result = '0;
        case (funct3)
            F3_B:  result = {{(XLEN-8){s[7]}}, s[7:0]};
            F3_H:  result = {{(XLEN-16){s[15]}}, s[15:0]};
            F3_W:  result = {{(XLEN-32){s[31]}}, s[31:0]};
            F3_D:  result = s;
            F3_BU: result = {{(XLEN-8){1'b0}}, s[7:0]};
            F3_HU: result = {{(XLEN-16){1'b0}}, s[15:0]};
            F3_WU: result = {{(XLEN-32){1'b0}}, s[31:0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: checks, issues and completes one data
// access per instruction, stalling the pipeline while it is outstanding.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN   = LSU_XLEN,
    parameter int STRB_W = XLEN/8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [2:0]          funct3,
    input  logic [XLEN-1:0]     addr,
    input  logic [XLEN-1:0]     store_data,
    load_store_unit_if.master   dmem,
    output logic [XLEN-1:0]     mem_data,
    output logic                mem_data_valid,
    output logic                stall,
    output logic                misaligned,
    output logic                access_fault
);

    lsu_state_t        state;
    logic              req_q;
    logic              we_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              is_ld_q;
    logic [2:0]        f3_q;
    logic [2:0]        lo_q;

    logic              idle;
    logic              access;
    logic              fault_c;
    logic              mis_c;
    logic              accept;
    logic [1:0]        sz;
    logic [STRB_W-1:0] strb_c;
    logic [XLEN-1:0]   wdata_c;
    logic [XLEN-1:0]   ld_fmt;

    assign idle   = (state == S_IDLE);
    assign access = idle & valid & (mem_read | mem_write);
    assign sz     = funct3[1:0];

    assign fault_c = (mem_read & mem_write)
                   | (mem_read & (funct3 == 3'b111))
                   | (mem_write & funct3[2]);

    always_comb begin
        mis_c = 1'b0;
        unique case (1'b1)
            (sz == 2'd0): mis_c = 1'b0;
            (sz == 2'd1): mis_c = addr[0];
            (sz == 2'd2): mis_c = |addr[1:0];
            (sz == 2'd3): mis_c = |addr[2:0];
        endcase
    end

    // A fault takes priority over misalignment; neither is issued.
    assign access_fault = access & fault_c;
    assign misaligned   = access & ~fault_c & mis_c;
    assign accept       = access & ~fault_c & ~mis_c;
    assign stall        = accept | (state == S_WAIT);

    always_comb begin
        strb_c  = '0;
        wdata_c = '0;
        unique case (1'b1)
            (sz == 2'd0): begin
                strb_c  = STRB_W'(8'h01) << addr[2:0];
                wdata_c = {(XLEN/8){store_data[7:0]}};
            end
            (sz == 2'd1): begin
                strb_c  = STRB_W'(8'h03) << addr[2:0];
                wdata_c = {(XLEN/16){store_data[15:0]}};
            end
            (sz == 2'd2): begin
                strb_c  = STRB_W'(8'h0F) << addr[2:0];
                wdata_c = {(XLEN/32){store_data[31:0]}};
            end
            (sz == 2'd3): begin
                strb_c  = '1;
                wdata_c = store_data;
            end
        endcase
    end

    load_align #(.XLEN(XLEN)) u_align (
        .rdata  (dmem.dmem_rdata),
        .addr   (lo_q),
        .funct3 (f3_q),
        .result (ld_fmt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            is_ld_q        <= 1'b0;
            f3_q           <= '0;
            lo_q           <= '0;
            mem_data       <= '0;
            mem_data_valid <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    mem_data_valid <= 1'b0;
                    if (accept) begin
                        state   <= S_WAIT;
                        req_q   <= 1'b1;
                        we_q    <= mem_write;
                        addr_q  <= {addr[XLEN-1:3], 3'b000};
                        wdata_q <= mem_write ? wdata_c : '0;
                        wstrb_q <= mem_write ? strb_c : '0;
                        is_ld_q <= mem_read;
                        f3_q    <= funct3;
                        lo_q    <= addr[2:0];
                    end
                end
                S_WAIT: begin
                    if (dmem.dmem_ready) begin
                        state          <= S_DONE;
                        req_q          <= 1'b0;
                        we_q           <= 1'b0;
                        addr_q         <= '0;
                        wdata_q        <= '0;
                        wstrb_q        <= '0;
                        mem_data_valid <= is_ld_q;
                        if (is_ld_q) begin
                            mem_data <= ld_fmt;
                        end
                    end
                end
                S_DONE: begin
                    // The stalled instruction is still presented here.
                    state          <= S_IDLE;
                    mem_data_valid <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_wstrb = wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a transaction-level model
// that sets per-cycle expectations checked on every falling edge.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] store_data;
    logic [63:0] mem_data;
    logic        mem_data_valid;
    logic        stall;
    logic        misaligned;
    logic        access_fault;

    load_store_unit_if #(.XLEN(64)) dif ();

    load_store_unit #(.XLEN(64), .STRB_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid          (valid),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .funct3         (funct3),
        .addr           (addr),
        .store_data     (store_data),
        .dmem           (dif),
        .mem_data       (mem_data),
        .mem_data_valid (mem_data_valid),
        .stall          (stall),
        .misaligned     (misaligned),
        .access_fault   (access_fault)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic        e_stall, e_mis, e_flt, e_req, e_we, e_mdv;
    logic [63:0] e_addr, e_wdata, e_md;
    logic [7:0]  e_wstrb;
    logic [63:0] md_model = 64'd0;

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", stall, e_stall);
            chk("misaligned", misaligned, e_mis);
            chk("access_fault", access_fault, e_flt);
            chk("dmem_req", dif.dmem_req, e_req);
            chk("dmem_we", dif.dmem_we, e_we);
            chk("dmem_addr", dif.dmem_addr, e_addr);
            chk("dmem_wdata", dif.dmem_wdata, e_wdata);
            chk("dmem_wstrb", dif.dmem_wstrb, e_wstrb);
            chk("mem_data", mem_data, e_md);
            chk("mem_data_valid", mem_data_valid, e_mdv);
        end
    end

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_fault(input bit rd, input bit wr,
                                   input logic [2:0] f3);
        return (rd && wr) || (rd && f3 == 3'd7) || (wr && f3[2]);
    endfunction

    function automatic bit m_mis(input logic [2:0] f3,
                                 input logic [63:0] a);
        return (int'(a[2:0]) % nbytes(f3)) != 0;
    endfunction

    function automatic logic [7:0] m_strb(input logic [2:0] f3,
                                          input logic [63:0] a);
        logic [7:0] s;
        int off;
        int n;
        s = 8'd0;
        off = int'(a[2:0]);
        n = nbytes(f3);
        for (int i = 0; i < 8; i++)
            if (i >= off && i < off + n) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [2:0] f3,
                                            input logic [63:0] sd);
        logic [63:0] w;
        int n;
        n = nbytes(f3);
        for (int i = 0; i < 8; i++)
            w[8*i +: 8] = sd[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [63:0] m_load(input logic [2:0] f3,
                                           input logic [63:0] a,
                                           input logic [63:0] w);
        logic [63:0] v;
        logic [63:0] mask;
        int bits;
        v = w >> (8 * int'(a[2:0]));
        bits = 8 * nbytes(f3);
        if (bits < 64) begin
            mask = (64'd1 << bits) - 64'd1;
            v = v & mask;
            if (!f3[2] && v[bits-1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic set_idle();
        e_stall = 1'b0; e_mis = 1'b0; e_flt = 1'b0;
        e_req = 1'b0; e_we = 1'b0; e_mdv = 1'b0;
        e_addr = 64'd0; e_wdata = 64'd0; e_wstrb = 8'd0;
        e_md = md_model;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            valid = 1'b0;
            dif.dmem_ready = 1'($urandom);
            dif.dmem_rdata = {$urandom, $urandom};
            set_idle();
            @(posedge clk); #1;
        end
    endtask

    task automatic access(input bit v, input bit rd, input bit wr,
                          input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] sd, input int dly,
                          input logic [63:0] rword, input int rst_at);
        bit acc, flt, mis;
        acc = v && (rd || wr);
        flt = acc && m_fault(rd, wr, f3);
        mis = acc && !flt && m_mis(f3, a);
        valid = v; mem_read = rd; mem_write = wr;
        funct3 = f3; addr = a; store_data = sd;
        dif.dmem_ready = 1'($urandom);
        dif.dmem_rdata = {$urandom, $urandom};
        set_idle();
        e_flt = flt;
        e_mis = mis;
        e_stall = acc && !flt && !mis;
        @(posedge clk); #1;
        if (!(acc && !flt && !mis)) begin
            valid = 1'b0;
            set_idle();
            return;
        end
        set_idle();
        e_stall = 1'b1;
        e_req = 1'b1;
        e_we = wr;
        e_addr = {a[63:3], 3'b000};
        e_wdata = wr ? m_wdata(f3, sd) : 64'd0;
        e_wstrb = wr ? m_strb(f3, a) : 8'd0;
        for (int i = 0; i <= dly; i++) begin
            if (i == rst_at) begin
                reset = 1'b1;
                dif.dmem_ready = 1'b0;
                @(posedge clk); #1;
                reset = 1'b0;
                valid = 1'b0;
                md_model = 64'd0;
                set_idle();
                return;
            end
            dif.dmem_ready = (i == dly);
            dif.dmem_rdata = (i == dly) ? rword : {$urandom, $urandom};
            @(posedge clk); #1;
        end
        dif.dmem_ready = 1'($urandom);
        dif.dmem_rdata = {$urandom, $urandom};
        if (rd) md_model = m_load(f3, a, rword);
        set_idle();
        e_mdv = rd;
        @(posedge clk); #1;
        valid = 1'b0;
        set_idle();
    endtask

    initial begin
        logic [63:0] ra;
        logic [2:0]  rf3;
        bit          rrd, rwr;
        reset = 1'b1; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'd0; addr = 64'd0; store_data = 64'd0;
        dif.dmem_ready = 1'b0; dif.dmem_rdata = 64'd0;
        set_idle();
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        idle_cycles(2);

        chk("pin_lb", m_load(3'b000, 64'h1003, 64'h8000_0000),
            64'hFFFF_FFFF_FFFF_FF80);
        chk("pin_lwu", m_load(3'b110, 64'h2004, 64'hDEAD_BEEF_0000_0001),
            64'h0000_0000_DEAD_BEEF);
        chk("pin_sh_strb", m_strb(3'b001, 64'h3006), 8'hC0);
        chk("pin_sh_wdata", m_wdata(3'b001, 64'h1234),
            64'h1234_1234_1234_1234);
        chk("pin_lw_mis", m_mis(3'b010, 64'h4002), 1'b1);
        chk("pin_sd_strb", m_strb(3'b011, 64'h8), 8'hFF);

        access(1, 1, 0, 3'b000, 64'h1003, 0, 0, 64'h8000_0000, -1);
        chk("lb_lit", mem_data, 64'hFFFF_FFFF_FFFF_FF80);
        access(1, 1, 0, 3'b110, 64'h2004, 0, 1,
               64'hDEAD_BEEF_0000_0001, -1);
        chk("lwu_lit", mem_data, 64'h0000_0000_DEAD_BEEF);
        access(1, 0, 1, 3'b001, 64'h3006, 64'h1234, 0, 0, -1);
        chk("sh_keeps_md", mem_data, 64'h0000_0000_DEAD_BEEF);
        access(1, 1, 0, 3'b010, 64'h4002, 0, 0, 0, -1);
        access(1, 1, 0, 3'b011, 64'h5000, 0, 3,
               64'h0123_4567_89AB_CDEF, -1);
        chk("ld_lit", mem_data, 64'h0123_4567_89AB_CDEF);
        access(1, 1, 1, 3'b011, 64'h6000, 0, 0, 0, -1);
        access(1, 1, 0, 3'b111, 64'h6000, 0, 0, 0, -1);
        access(1, 0, 1, 3'b100, 64'h6000, 0, 0, 0, -1);
        access(1, 1, 0, 3'b011, 64'h7000, 0, 5,
               64'hAAAA_BBBB_CCCC_DDDD, 1);
        @(negedge clk);
        chk("rst_md", mem_data, 64'd0);
        chk("rst_req", dif.dmem_req, 1'b0);
        @(posedge clk); #1;
        idle_cycles(1);

        for (int k = 0; k < 400; k++) begin
            rf3 = 3'($urandom);
            ra = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) ra[2:0] = 3'd0;
            rrd = 1'($urandom);
            rwr = ($urandom_range(0, 9) == 0) ? rrd : !rrd;
            access(($urandom_range(0, 7) != 0), rrd, rwr, rf3, ra,
                   {$urandom, $urandom}, $urandom_range(0, 4),
                   {$urandom, $urandom}, -1);
            if ($urandom_range(0, 3) == 0) idle_cycles(1);
        end

        idle_cycles(2);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
